// File: rtl/reset_sequencer.sv
// Central reset sequencer: asserts all stage resets on hard reset, then releases
// them one by one in index order, gated by a hold time and the previous stage's ack.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int SYNC_DEPTH     = 2,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_rst_req_i,
    input  logic [NUM_STAGES-1:0] stage_ack_i,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  all_released_o,
    output logic                  sw_rst_ack_o,
    output logic                  err_o,
    output logic [3:0]            err_stage_o
);

    localparam int              CNT_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_STAGE = 4'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                  r_state;
    logic [SYNC_DEPTH-1:0]   r_sync;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_k;
    logic [NUM_STAGES-1:0]   r_rst;
    logic                    r_all_rel;
    logic                    r_sw_ack;
    logic                    r_err;
    logic [3:0]              r_err_stage;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [3:0]              w_k_nxt;
    logic [NUM_STAGES-1:0]   w_rst_nxt;
    logic                    w_all_rel_nxt;
    logic                    w_sw_ack_nxt;
    logic                    w_err_nxt;
    logic [3:0]              w_err_stage_nxt;

    logic                    w_rst_sync;
    logic [15:0]             w_ack_ext;
    logic                    w_ack_k;
    logic                    w_hold_done;
    logic                    w_at_timeout;
    logic                    w_advance;
    logic                    w_timeout;
    logic [3:0]              w_k_inc;
    logic [NUM_STAGES-1:0]   w_next_bit;

    // Deassertion synchronizer; not touched by software reset so ASSERT counts at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign w_rst_sync   = r_sync[SYNC_DEPTH-1];
    assign w_ack_ext    = 16'(stage_ack_i);
    assign w_ack_k      = w_ack_ext[r_k];
    assign w_hold_done  = (r_cnt >= HOLD_LAST);
    assign w_at_timeout = (r_cnt == TO_LAST);
    assign w_k_inc      = r_k + 4'd1;

    always_comb begin
        w_next_bit = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_next_bit[i] = (4'(i) == w_k_inc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ASSERT;
            r_cnt       <= '0;
            r_k         <= '0;
            r_rst       <= '1;
            r_all_rel   <= 1'b0;
            r_sw_ack    <= 1'b0;
            r_err       <= 1'b0;
            r_err_stage <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_k         <= w_k_nxt;
            r_rst       <= w_rst_nxt;
            r_all_rel   <= w_all_rel_nxt;
            r_sw_ack    <= w_sw_ack_nxt;
            r_err       <= w_err_nxt;
            r_err_stage <= w_err_stage_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_k_nxt         = r_k;
        w_rst_nxt       = r_rst;
        w_all_rel_nxt   = r_all_rel;
        w_sw_ack_nxt    = 1'b0;
        w_err_nxt       = r_err;
        w_err_stage_nxt = r_err_stage;
        w_advance       = 1'b0;
        w_timeout       = 1'b0;

        unique case (r_state)
            ST_ASSERT: begin
                w_rst_nxt = '1;
                if (w_rst_sync) begin
                    if (r_cnt == HOLD_LAST) begin
                        w_rst_nxt[0] = 1'b0;
                        w_k_nxt      = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                // An early ack is held off until the hold time has elapsed.
                if (w_hold_done && w_ack_k) begin
                    w_advance = 1'b1;
                end else if (w_at_timeout) begin
                    w_advance = 1'b1;
                    w_timeout = 1'b1;
                end

                if (w_timeout) begin
                    w_err_nxt = 1'b1;
                    if (!r_err) begin
                        w_err_stage_nxt = r_k;
                    end
                end

                if (w_advance) begin
                    w_cnt_nxt = '0;
                    if (r_k == LAST_STAGE) begin
                        w_state_nxt   = ST_RUN;
                        w_all_rel_nxt = 1'b1;
                    end else begin
                        w_k_nxt   = w_k_inc;
                        w_rst_nxt = r_rst & ~w_next_bit;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                w_rst_nxt     = '0;
                w_all_rel_nxt = 1'b1;
                if (sw_rst_req_i) begin
                    w_rst_nxt     = '1;
                    w_all_rel_nxt = 1'b0;
                    w_sw_ack_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_k_nxt       = '0;
                    w_state_nxt   = ST_ASSERT;
                end
            end

            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase
    end

    assign rst_o          = r_rst;
    assign all_released_o = r_all_rel;
    assign sw_rst_ack_o   = r_sw_ack;
    assign err_o          = r_err;
    assign err_stage_o    = r_err_stage;

endmodule
